// File: rtl/proc_io_arbiter_if.sv
// Requester-side bundle for proc_io_arbiter: request and response channels
// with valid/ready handshakes, one bit per requester.
interface proc_io_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    resp_valid;
  logic [DW-1:0]      resp_data;
  logic [NREQ-1:0]    resp_ready;

  // Requester fabric drives requests and takes responses
  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  // Arbiter accepts requests and returns responses
  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/proc_io_arbiter.sv
// Round-robin arbiter sharing the processor data_in/data_out pair between
// NREQ requesters. One word is in flight at a time: it is held on
// proc_data_in for LATENCY cycles, the processor output is then sampled and
// handed back to the granted requester.
module proc_io_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 32,
  parameter int LATENCY = 4,
  localparam int GW     = $clog2((NREQ > 2) ? NREQ : 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  proc_io_arbiter_if.slave     bus,
  output logic [DW-1:0]        proc_data_in,
  input  logic [DW-1:0]        proc_data_out,
  output logic [GW-1:0]        grant_id,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  localparam logic [7:0]    CNT_INIT = 8'(LATENCY - 1);
  localparam logic [GW-1:0] LAST_ID  = GW'(NREQ - 1);

  state_t        state;
  logic [GW-1:0] ptr;
  logic [7:0]    cnt;
  logic [GW-1:0] pick_id;
  logic          pick_found;

  // Find the first pending requester at or above ptr, wrapping; scanning
  // offsets downward lets the smallest offset win.
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (bus.req_valid[idx]) begin
        pick_found = 1'b1;
        pick_id    = GW'(idx);
      end
    end
  end

  // Accept strobe is offered only while idle and out of reset.
  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && pick_found && !rst)
      bus.req_ready[pick_id] = 1'b1;
  end

  // Transaction FSM: accept, hold the word for LATENCY cycles, capture the
  // processor output, then wait for the granted requester to take it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= '0;
      cnt            <= '0;
      proc_data_in   <= '0;
      grant_id       <= '0;
      busy           <= 1'b0;
      bus.resp_valid <= '0;
      bus.resp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            proc_data_in <= bus.req_data[int'(pick_id)*DW +: DW];
            grant_id     <= pick_id;
            cnt          <= CNT_INIT;
            busy         <= 1'b1;
            state        <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt == 8'd0) begin
            bus.resp_data  <= proc_data_out;
            bus.resp_valid <= NREQ'(1) << grant_id;
            state          <= RESP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready[grant_id]) begin
            bus.resp_valid <= '0;
            ptr            <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
            busy           <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_io_arbiter.sv
// Directed bench for proc_io_arbiter with an echo-plus-one processor model
// and a scoreboard of expected responses.
module tb_proc_io_arbiter;
  localparam int NREQ    = 4;
  localparam int DW      = 32;
  localparam int LATENCY = 4;

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] proc_data_in;
  logic [DW-1:0] proc_data_out;
  logic [1:0]    grant_id;
  logic          busy;
  logic [DW-1:0] req_word [NREQ];

  int   checks    = 0;
  int   failures  = 0;
  int   model_ptr = 0;
  int   cycle     = 0;
  int   accept_cycle;
  exp_t sb [$];

  proc_io_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  proc_io_arbiter #(.NREQ(NREQ), .DW(DW), .LATENCY(LATENCY)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .proc_data_in  (proc_data_in),
    .proc_data_out (proc_data_out),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Cycle counter used to measure spacing between accept edges
  always @(posedge clk) cycle <= cycle + 1;

  assign proc_data_out = proc_data_in + 32'd1;

  for (genvar i = 0; i < NREQ; i++) begin : g_pack
    assign bus.req_data[i*DW +: DW] = req_word[i];
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ-1:0] rready);
    bus.req_valid  = valid;
    bus.resp_ready = rready;
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // Called at a negedge in IDLE with inputs set; returns at the negedge after the accept edge.
  task automatic step_accept(input string tag);
    int              g;
    exp_t            e;
    logic [NREQ-1:0] oh;
    #1;
    g  = model_pick(bus.req_valid, model_ptr);
    oh = '0;
    if (g >= 0) oh[g] = 1'b1;
    checkOutput({tag, "_req_ready"}, 64'(bus.req_ready), 64'(oh));
    if (g < 0) g = 0;
    e.id   = g;
    e.data = req_word[g] + 32'd1;
    sb.push_back(e);
    @(posedge clk);
    accept_cycle = cycle;
    @(negedge clk);
    checkOutput({tag, "_proc_data_in"}, 64'(proc_data_in), 64'(req_word[g]));
    checkOutput({tag, "_grant_id"}, 64'(grant_id), 64'(g));
    checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
  endtask

  // Waits (bounded) for resp_valid and compares against the scoreboard head.
  task automatic wait_resp(input string tag, output exp_t e);
    int n = 0;
    while (bus.resp_valid == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_latency"}, 64'(n), 64'(LATENCY));
    if (sb.size() > 0) e = sb.pop_front();
    else begin
      e.id = 0;
      e.data = '0;
    end
    checkOutput({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'(4'b0001 << e.id));
    checkOutput({tag, "_resp_data"}, 64'(bus.resp_data), 64'(e.data));
  endtask

  // Called at the negedge following the handshake edge.
  task automatic finish_resp(input string tag, input int id);
    checkOutput({tag, "_resp_clear"}, 64'(bus.resp_valid), 64'd0);
    checkOutput({tag, "_busy_clear"}, 64'(busy), 64'd0);
    model_ptr = (id + 1) % NREQ;
  endtask

  initial begin
    exp_t e;
    int   prev_accept;
    rst = 1'b1;
    applyStimulus(4'b0000, 4'b0000);
    for (int i = 0; i < NREQ; i++) req_word[i] = '0;

    // Reset and idle
    repeat (3) @(negedge clk);
    checkOutput("rst_proc_data_in", 64'(proc_data_in), 64'd0);
    checkOutput("rst_resp_data", 64'(bus.resp_data), 64'd0);
    checkOutput("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    checkOutput("rst_grant_id", 64'(grant_id), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_req_ready", 64'(bus.req_ready), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idle_busy", 64'(busy), 64'd0);
      checkOutput("idle_req_ready", 64'(bus.req_ready), 64'd0);
    end

    // Round-robin rotation, all requesters valid
    for (int i = 0; i < NREQ; i++) req_word[i] = $urandom;
    applyStimulus(4'b1111, 4'b1111);
    prev_accept = 0;
    for (int t = 0; t < 5; t++) begin
      step_accept("rr");
      checkOutput("rr_order", 64'(grant_id), 64'(t % NREQ));
      if (t > 0) checkOutput("rr_spacing", 64'(accept_cycle - prev_accept), 64'(LATENCY + 2));
      prev_accept = accept_cycle;
      if (t == 4) applyStimulus(4'b0000, 4'b1111);
      wait_resp("rr", e);
      @(negedge clk);
      finish_resp("rr", e.id);
    end

    // Single transaction from requester 2
    req_word[2] = 32'h0000_00A5;
    applyStimulus(4'b0100, 4'b0100);
    step_accept("single");
    applyStimulus(4'b0000, 4'b0100);
    wait_resp("single", e);
    checkOutput("single_data_A6", 64'(bus.resp_data), 64'h0000_00A6);
    @(negedge clk);
    finish_resp("single", e.id);

    // Response backpressure on requester 1
    req_word[1] = 32'h1234_5678;
    applyStimulus(4'b0010, 4'b0000);
    step_accept("bp");
    applyStimulus(4'b0000, 4'b0000);
    wait_resp("bp", e);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0000, (i % 2 == 0) ? 4'b1101 : 4'b0000);
      @(negedge clk);
      checkOutput("bp_hold_valid", 64'(bus.resp_valid), 64'b0010);
      checkOutput("bp_hold_data", 64'(bus.resp_data), 64'(e.data));
    end
    applyStimulus(4'b0000, 4'b0010);
    @(negedge clk);
    finish_resp("bp", e.id);

    // Wrap and withdrawal: serve req 2 so ptr becomes 3, then req 3 drops out
    req_word[2] = 32'hCAFE_0002;
    req_word[0] = 32'h0BAD_F00D;
    req_word[3] = 32'h3333_3333;
    applyStimulus(4'b0100, 4'b0000);
    step_accept("wrap_pre");
    applyStimulus(4'b0000, 4'b0000);
    wait_resp("wrap_pre", e);
    applyStimulus(4'b1001, 4'b0000);
    @(negedge clk);
    applyStimulus(4'b0001, 4'b0100);
    @(negedge clk);
    finish_resp("wrap_pre", e.id);
    checkOutput("wrap_ptr_model", 64'(model_ptr), 64'd3);
    step_accept("wrap");
    checkOutput("wrap_no_req3", 64'(grant_id), 64'd0);
    applyStimulus(4'b0000, 4'b1111);
    wait_resp("wrap", e);
    @(negedge clk);
    finish_resp("wrap", e.id);

    // Reset two cycles into DRIVE for requester 3
    req_word[3] = 32'h0000_0333;
    req_word[1] = 32'h0000_0111;
    applyStimulus(4'b1000, 4'b0000);
    step_accept("mid");
    applyStimulus(4'b1010, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_proc_data_in", 64'(proc_data_in), 64'd0);
    checkOutput("mid_resp_data", 64'(bus.resp_data), 64'd0);
    checkOutput("mid_resp_valid", 64'(bus.resp_valid), 64'd0);
    checkOutput("mid_grant_id", 64'(grant_id), 64'd0);
    checkOutput("mid_busy", 64'(busy), 64'd0);
    checkOutput("mid_req_ready", 64'(bus.req_ready), 64'd0);
    sb.delete();
    model_ptr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("mid_no_resp", 64'(bus.resp_valid), 64'd0);
    end
    rst = 1'b0;
    applyStimulus(4'b1010, 4'b1111);
    step_accept("post_rst");
    checkOutput("post_rst_grant1", 64'(grant_id), 64'd1);
    applyStimulus(4'b0000, 4'b1111);
    wait_resp("post_rst", e);
    @(negedge clk);
    finish_resp("post_rst", e.id);
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
